// File: rtl/mem_access_unit_way0.sv
// Way-0 memory access unit: one outstanding load/store against a 64-bit RAM port, result held
// for the load-extract stage. Define MEM_MISALIGN_TRAP_EN to trap size-misaligned accesses.
module mem_access_unit_way0 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // upstream request
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [63:0] storeData_i,
  input  logic        rdWriteEnable_i,
  input  logic [4:0]  rdAddr_i,
  input  logic [63:0] rdData_i,
  input  logic [1:0]  way0_pID_i,
  // RAM side
  output logic        readReq_o,
  output logic [31:0] readAddr_o,
  output logic        writeReq_o,
  output logic [31:0] writeAddr_o,
  output logic [63:0] writeData_o,
  output logic [7:0]  writeMask_o,
  input  logic [63:0] readData_i,
  input  logic        dataOk_i,
  // load-extract stage
  output logic        valid_o,
  input  logic        ready_i,
  output logic        rdWriteEnable_o,
  output logic [4:0]  rdAddr_o,
  output logic [63:0] rdData_o,
  output logic [1:0]  way0_pID_o,
  output logic [2:0]  funct3_o,
  output logic [63:0] readData_o,
  output logic        busErr_o,
  output logic        misalign_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e state_q, state_d;

  logic            accept;
  logic            trap;
  logic            time_out;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;

  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [63:0] store_data_q;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;
  logic [63:0] rd_data_q;
  logic [1:0]  pid_q;
  logic [63:0] read_data_q;
  logic        bus_err_q;

  logic [5:0] lane_shift;
  logic [7:0] size_mask;

  assign accept   = valid_i && (state_q == StIdle);
  // cnt_q counts completed wait cycles, so cnt_inc is the number of the current cycle
  assign cnt_inc  = cnt_q + CntW'(1);
  assign time_out = (cnt_inc == CntW'(TIMEOUT));

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_acc;
  logic misalign_q;

  always_comb begin
    misalign_acc = 1'b0;
    unique case (funct3_i[1:0])
      2'b01:   misalign_acc = addr_i[0];
      2'b10:   misalign_acc = |addr_i[1:0];
      2'b11:   misalign_acc = |addr_i[2:0];
      default: misalign_acc = 1'b0;
    endcase
  end

  assign trap = (memRead_i || memWrite_i) && misalign_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= trap;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (trap)            state_d = StResp;
          else if (memRead_i)  state_d = StRead;
          else if (memWrite_i) state_d = StWrite;
          else                 state_d = StResp;
        end
      end
      StRead, StWrite: begin
        if (dataOk_i || time_out) state_d = StResp;
      end
      StResp: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and request outputs
  always_comb begin
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    readReq_o  = 1'b0;
    writeReq_o = 1'b0;
    unique case (state_q)
      StIdle:  ready_o    = 1'b1;
      StRead:  readReq_o  = 1'b1;
      StWrite: writeReq_o = 1'b1;
      StResp:  valid_o    = 1'b1;
      default: ;
    endcase
  end

  // Captured command, writeback fields, result and wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      rd_we_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      pid_q        <= '0;
      read_data_q  <= '0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else if (accept) begin
      funct3_q     <= funct3_i;
      addr_q       <= addr_i;
      store_data_q <= storeData_i;
      rd_we_q      <= rdWriteEnable_i && !trap;
      rd_addr_q    <= rdAddr_i;
      rd_data_q    <= rdData_i;
      pid_q        <= way0_pID_i;
      read_data_q  <= '0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else if (state_q == StRead || state_q == StWrite) begin
      if (dataOk_i) begin
        if (state_q == StRead) read_data_q <= readData_i >> lane_shift;
      end else if (time_out) begin
        bus_err_q   <= 1'b1;
        read_data_q <= '0;
        rd_we_q     <= 1'b0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  always_comb begin
    unique case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Byte lanes past the doubleword are shifted out and dropped
  assign lane_shift  = {addr_q[2:0], 3'b000};
  assign readAddr_o  = {addr_q[31:3], 3'b000};
  assign writeAddr_o = {addr_q[31:3], 3'b000};
  assign writeData_o = store_data_q << lane_shift;
  assign writeMask_o = size_mask << addr_q[2:0];

  assign rdWriteEnable_o = rd_we_q;
  assign rdAddr_o        = rd_addr_q;
  assign rdData_o        = rd_data_q;
  assign way0_pID_o      = pid_q;
  assign funct3_o        = funct3_q;
  assign readData_o      = read_data_q;
  assign busErr_o        = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit_way0.sv
// Scoreboard bench for mem_access_unit_way0: byte-lane reference model, RAM responder, monitor.
module tb_mem_access_unit_way0;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        memRead_i = 1'b0;
  logic        memWrite_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [63:0] storeData_i = '0;
  logic        rdWriteEnable_i = 1'b0;
  logic [4:0]  rdAddr_i = '0;
  logic [63:0] rdData_i = '0;
  logic [1:0]  way0_pID_i = '0;
  logic        readReq_o;
  logic [31:0] readAddr_o;
  logic        writeReq_o;
  logic [31:0] writeAddr_o;
  logic [63:0] writeData_o;
  logic [7:0]  writeMask_o;
  logic [63:0] readData_i = '0;
  logic        dataOk_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        rdWriteEnable_o;
  logic [4:0]  rdAddr_o;
  logic [63:0] rdData_o;
  logic [1:0]  way0_pID_o;
  logic [2:0]  funct3_o;
  logic [63:0] readData_o;
  logic        busErr_o;
  logic        misalign_o;

  mem_access_unit_way0 #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .storeData_i(storeData_i), .rdWriteEnable_i(rdWriteEnable_i), .rdAddr_i(rdAddr_i),
    .rdData_i(rdData_i), .way0_pID_i(way0_pID_i), .readReq_o(readReq_o),
    .readAddr_o(readAddr_o), .writeReq_o(writeReq_o), .writeAddr_o(writeAddr_o),
    .writeData_o(writeData_o), .writeMask_o(writeMask_o), .readData_i(readData_i),
    .dataOk_i(dataOk_i), .valid_o(valid_o), .ready_i(ready_i),
    .rdWriteEnable_o(rdWriteEnable_o), .rdAddr_o(rdAddr_o), .rdData_o(rdData_o),
    .way0_pID_o(way0_pID_o), .funct3_o(funct3_o), .readData_o(readData_o),
    .busErr_o(busErr_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] sdata;
    bit          rwe;
    logic [4:0]  rda;
    logic [63:0] rdd;
    logic [1:0]  pid;
    int unsigned dly;
    logic [63:0] ram;
    int unsigned hold;
  } txn_t;

  typedef struct {
    bit          rwe;
    logic [4:0]  rda;
    logic [63:0] rdd;
    logic [1:0]  pid;
    logic [2:0]  f3;
    bit          err;
    bit          mis;
    logic [63:0] rdata;
    bit          chk_rdata;
    int unsigned vcyc;
    int unsigned hold;
  } exp_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    int unsigned dly;
    logic [63:0] ram;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    ram_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model in byte lanes: lane i of the RAM word carries address byte base+i
  function automatic logic [63:0] model_load(input logic [63:0] ram, input int unsigned off);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) if (i + off < 8) r[i*8 +: 8] = ram[(i+off)*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] sd, input int unsigned off);
    logic [63:0] r = '0;
    for (int j = 0; j < 8; j++) if (j >= off) r[j*8 +: 8] = sd[(j-off)*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] model_mask(input int unsigned size, input int unsigned off);
    logic [7:0] m = '0;
    for (int j = 0; j < 8; j++) if (j >= off && j < off + size) m[j] = 1'b1;
    return m;
  endfunction

  task automatic issue(input txn_t t);
    exp_t        e;
    plan_t       p;
    int unsigned n, size, off;
    bit          mem, trap, err;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready_o, 1);
    if (!ready_o) return;
    size = 1 << t.f3[1:0];
    off  = t.addr % 8;
    mem  = t.rd || t.wr;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mem && (t.addr % size != 0);
`else
    trap = 1'b0;
`endif
    err  = mem && !trap && (t.dly >= TO);
    valid_i = 1'b1; memRead_i = t.rd; memWrite_i = t.wr; funct3_i = t.f3; addr_i = t.addr;
    storeData_i = t.sdata; rdWriteEnable_i = t.rwe; rdAddr_i = t.rda; rdData_i = t.rdd;
    way0_pID_i = t.pid;
    e.rwe = t.rwe && !trap && !err;
    e.rda = t.rda; e.rdd = t.rdd; e.pid = t.pid; e.f3 = t.f3;
    e.err = err; e.mis = trap;
    e.rdata = err ? 64'h0 : model_load(t.ram, off);
    e.chk_rdata = t.rd && !trap;
    e.vcyc = cyc + 1 + ((mem && !trap) ? (err ? TO : t.dly + 1) : 0);
    e.hold = t.hold;
    exp_q.push_back(e);
    if (mem && !trap) begin
      p.is_rd = t.rd;
      p.addr  = t.addr - off;
      p.wdata = model_wdata(t.sdata, off);
      p.mask  = model_mask(size, off);
      p.dly   = t.dly;
      p.ram   = t.ram;
      plan_q.push_back(p);
    end
    @(negedge clk);
    valid_i = 1'b0;
    memRead_i = $urandom_range(0, 1); memWrite_i = $urandom_range(0, 1);
    addr_i = $urandom; storeData_i = {$urandom, $urandom};
  endtask

  // RAM responder: checks each request against the plan and answers after the planned delay
  initial begin
    int unsigned k = 0;
    bit          busy = 1'b0;
    plan_t       p;
    forever begin
      @(negedge clk);
      if (!ram_en) continue;
      chk("req_exclusive", readReq_o & writeReq_o, 0);
      if (readReq_o || writeReq_o) begin
        if (!busy) begin
          if (plan_q.size() == 0) begin
            chk("unplanned_req", {readReq_o, writeReq_o}, 0);
          end else begin
            p = plan_q.pop_front();
            busy = 1'b1;
            k = 0;
            chk("req_kind", {readReq_o, writeReq_o}, {p.is_rd, !p.is_rd});
            if (p.is_rd) begin
              chk("read_addr", readAddr_o, p.addr);
            end else begin
              chk("write_addr", writeAddr_o, p.addr);
              chk("write_data", writeData_o, p.wdata);
              chk("write_mask", writeMask_o, p.mask);
            end
          end
        end
        if (busy) begin
          dataOk_i = (k == p.dly) && (p.dly < TO);
          readData_i = dataOk_i ? p.ram : {$urandom, $urandom};
          k++;
        end
      end else begin
        if (busy) begin
          chk("req_cycles", k, (p.dly < TO) ? p.dly + 1 : TO);
          busy = 1'b0;
        end
        dataOk_i = ($urandom_range(0, 7) == 0);
        readData_i = {$urandom, $urandom};
      end
    end
  end

  // Monitor: pops the scoreboard on each new response, checks hold under back-pressure
  initial begin
    bit           in_resp = 1'b0;
    bit           prev_hs = 1'b0;
    int unsigned  stall = 0;
    exp_t         e;
    logic [159:0] snap, now;
    forever begin
      @(negedge clk);
      now = {rdWriteEnable_o, rdAddr_o, rdData_o, way0_pID_o, funct3_o, readData_o,
             busErr_o, misalign_o};
      if (!reset_n) begin
        in_resp = 1'b0;
        prev_hs = 1'b0;
        ready_i = 1'b0;
        continue;
      end
      if (prev_hs) begin
        chk("valid_drop", valid_o, 0);
        in_resp = 1'b0;
      end
      if (valid_o && !in_resp) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", valid_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.vcyc);
          chk("rd_we", rdWriteEnable_o, e.rwe);
          chk("rd_addr", rdAddr_o, e.rda);
          chk("rd_data", rdData_o, e.rdd);
          chk("pid", way0_pID_o, e.pid);
          chk("funct3", funct3_o, e.f3);
          chk("bus_err", busErr_o, e.err);
          chk("misalign", misalign_o, e.mis);
          if (e.chk_rdata) chk("read_data", readData_o, e.rdata);
          in_resp = 1'b1;
          stall = e.hold;
          snap = now;
        end
      end else if (in_resp) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_outputs", now, snap);
      end
      if (in_resp && stall > 0) begin
        ready_i = 1'b0;
        stall--;
      end else begin
        ready_i = ($urandom_range(0, 3) != 0);
      end
      prev_hs = in_resp && valid_o && ready_i;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    txn_t t;
    int unsigned n;
    int unsigned size;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_reqs", {readReq_o, writeReq_o}, 0);
    chk("reset_regs", {busErr_o, misalign_o, rdWriteEnable_o, readData_o, rdData_o}, 0);

    // Reset in the middle of a read
    valid_i = 1'b1; memRead_i = 1'b1; memWrite_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h1004; rdWriteEnable_i = 1'b1; rdData_i = 64'h55;
    @(negedge clk);
    valid_i = 1'b0; memRead_i = 1'b0;
    @(negedge clk);
    chk("mid_read_req", readReq_o, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_drops_req", readReq_o, 0);
    chk("reset_valid_low", valid_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", ready_o, 1);
    chk("post_reset_valid", valid_o, 0);
    chk("post_reset_rd_we", rdWriteEnable_o, 0);
    ram_en = 1'b1;

    // Directed: pass-through with a 3-cycle stall
    t = '{rd: 0, wr: 0, f3: 3'b000, addr: 32'h0, sdata: 64'h0, rwe: 1, rda: 5'd7,
          rdd: 64'h1234, pid: 2'd1, dly: 0, ram: 64'h0, hold: 3};
    issue(t);
    // Directed: lw 0x1004 answered on the 4th request cycle
    t = '{rd: 1, wr: 0, f3: 3'b010, addr: 32'h1004, sdata: 64'h0, rwe: 1, rda: 5'd3,
          rdd: 64'h0, pid: 2'd2, dly: 3, ram: 64'hAABBCCDD_11223344, hold: 0};
    issue(t);
    // Directed: sh 0x2006
    t = '{rd: 0, wr: 1, f3: 3'b001, addr: 32'h2006, sdata: 64'hBEEF, rwe: 0, rda: 5'd0,
          rdd: 64'h0, pid: 2'd0, dly: 1, ram: 64'h0, hold: 0};
    issue(t);
    // Directed: read that never gets dataOk
    t = '{rd: 1, wr: 0, f3: 3'b011, addr: 32'h3000, sdata: 64'h0, rwe: 1, rda: 5'd9,
          rdd: 64'h77, pid: 2'd3, dly: TO, ram: 64'h0, hold: 0};
    issue(t);
    // Directed: misaligned lw
    t = '{rd: 1, wr: 0, f3: 3'b010, addr: 32'h1002, sdata: 64'h0, rwe: 1, rda: 5'd4,
          rdd: 64'h0, pid: 2'd1, dly: 0, ram: 64'h0123_4567_89AB_CDEF, hold: 0};
    issue(t);

    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 3);
      t.rd = (n == 1) || (n == 3);
      t.wr = (n == 2) || (n == 3);
      t.f3 = $urandom_range(0, 7);
      size = 1 << t.f3[1:0];
      t.addr = $urandom;
      if ($urandom_range(0, 1) == 1) t.addr = t.addr - (t.addr % size);
      t.sdata = {$urandom, $urandom};
      t.rwe = $urandom_range(0, 1);
      t.rda = $urandom_range(0, 31);
      t.rdd = {$urandom, $urandom};
      t.pid = $urandom_range(0, 3);
      t.dly = $urandom_range(0, TO + 1);
      t.ram = {$urandom, $urandom};
      t.hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      issue(t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((exp_q.size() != 0 || !ready_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("plan_drained", plan_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit_way0.md
MEM_ACCESS_UNIT_WAY0 -- requirements
Module: mem_access_unit_way0

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles waiting for dataOk_i before abort; counter width $clog2(TIMEOUT+1).
REQ-002 SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: valid_i in 1, ready_o out 1; upstream request handshake.
REQ-005 SHALL have ports: memRead_i in 1, memWrite_i in 1, funct3_i in 3, addr_i in 32, storeData_i in 64; access command.
REQ-006 SHALL have ports: rdWriteEnable_i in 1, rdAddr_i in 5, rdData_i in 64, way0_pID_i in 2; writeback fields, captured on accept.
REQ-007 SHALL have ports: readReq_o out 1, readAddr_o out 32, writeReq_o out 1, writeAddr_o out 32, writeData_o out 64, writeMask_o out 8, readData_i in 64, dataOk_i in 1; RAM side.
REQ-008 SHALL have ports: valid_o out 1, ready_i in 1, rdWriteEnable_o out 1, rdAddr_o out 5, rdData_o out 64, way0_pID_o out 2, funct3_o out 3, readData_o out 64, busErr_o out 1, misalign_o out 1; to load-extract stage.

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-010 SHALL drive ready_o=1 only in IDLE; accept on valid_i&&ready_o, capturing all command and writeback fields.
REQ-011 On accept SHALL go: memRead_i -> READ; else memWrite_i -> WRITE; else -> RESP (pass-through); memRead_i has priority if both set.
REQ-012 READ SHALL hold readReq_o=1, readAddr_o={addr[31:3],3'b000} until dataOk_i; then capture readData_i>>(addr[2:0]*8) into readData_o, go RESP.
REQ-013 WRITE SHALL hold writeReq_o=1, writeAddr_o={addr[31:3],3'b000}, writeData_o=storeData<<(addr[2:0]*8), writeMask_o per REQ-014, until dataOk_i; then go RESP.
REQ-014 writeMask_o SHALL be, by funct3[1:0]: 00 8'h01, 01 8'h03, 10 8'h0F, 11 8'hFF, shifted left by addr[2:0], bits past 7 dropped.
REQ-015 READ/WRITE SHALL count cycles from entry; on count==TIMEOUT without dataOk_i SHALL drop request, set busErr_o=1, readData_o=0, rdWriteEnable_o=0, go RESP.
REQ-016 RESP SHALL hold valid_o=1 and all outputs stable until ready_i; on valid_o&&ready_i go IDLE same edge, valid_o=0 next cycle.
REQ-017 Latency: non-memory op valid_o one cycle after accept; memory op valid_o one cycle after dataOk_i sampled.
REQ-018 readReq_o/writeReq_o SHALL be 0 outside READ/WRITE; never both 1.
REQ-019 dataOk_i SHALL be ignored in IDLE and RESP.
REQ-020 busErr_o and misalign_o SHALL clear on next accept.

Reset
REQ-021 reset_n low SHALL immediately force IDLE, abandon any transaction, drop readReq_o/writeReq_o, zero all registered outputs and timeout counter; valid_o=0.
REQ-022 After reset ready_o SHALL be 1 (IDLE).

Configuration
REQ-023 Macro MEM_MISALIGN_TRAP_EN defined: access with addr not aligned to size (half addr[0], word addr[1:0], double addr[2:0] nonzero) SHALL issue no RAM request, go directly to RESP with misalign_o=1, rdWriteEnable_o=0.
REQ-024 Macro undefined: misalign_o tied 0; misaligned access issued per REQ-012/013, bytes crossing the doubleword dropped.

Verification
REQ-025 Reset: reset_n low mid-READ -> readReq_o=0 same cycle, after release ready_o=1, valid_o=0.
REQ-026 Pass-through: valid_i=1, no mem op, rdData_i=64'h1234 -> next cycle valid_o=1, rdData_o=64'h1234; ready_i=0 three cycles -> outputs held.
REQ-027 Load: lw addr=0x1004, RAM returns 64'hAABBCCDD_11223344 after 3 cycles -> readAddr_o=0x1000, readData_o=64'h00000000_AABBCCDD, valid_o cycle after dataOk_i.
REQ-028 Store: sh addr=0x2006, storeData=64'hBEEF -> writeMask_o=8'hC0, writeData_o=64'hBEEF0000_00000000, writeAddr_o=0x2000.
REQ-029 Timeout: TIMEOUT=4, read, dataOk_i never -> readReq_o drops after 4 cycles, valid_o=1, busErr_o=1, rdWriteEnable_o=0.
REQ-030 Misalign: lw addr=0x1002 with MEM_MISALIGN_TRAP_EN -> no readReq_o, misalign_o=1; without -> readReq_o=1, misalign_o=0.
